// File: rtl/glip_uart_egress_scheduler_if.sv
// Handshake bundle around the egress scheduler: out-FIFO read side, control ack
// request/grant and the UART transmit engine byte handshake.
interface glip_uart_egress_scheduler_if;
  logic [7:0] egress_in_data;
  logic       egress_in_valid;
  logic       egress_in_ready;
  logic       ctrl_ack_req;
  logic [5:0] ctrl_ack_code;
  logic       ctrl_ack_grant;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_done;

  modport master (
    input  egress_in_data, egress_in_valid, ctrl_ack_req, ctrl_ack_code, tx_done,
    output egress_in_ready, ctrl_ack_grant, tx_data, tx_enable
  );

  modport slave (
    output egress_in_data, egress_in_valid, ctrl_ack_req, ctrl_ack_code, tx_done,
    input  egress_in_ready, ctrl_ack_grant, tx_data, tx_enable
  );
endinterface

// File: rtl/glip_uart_egress_scheduler.sv
// Shares the UART transmitter between data bytes (0xFE escaped), credit-return
// messages and control acknowledges, with saturating credit bookkeeping.
//
// state | meaning
// IDLE  | arbitrating: ack > credit > data, only while uart_cts_n=0
// DATA  | sending the FIFO head byte
// ESC2  | sending the second 0xFE of an escaped data byte
// MSG0  | sending the 0xFE message marker
// MSG1  | sending ack code or upper credit bits
// MSG2  | sending lower credit bits
module glip_uart_egress_scheduler #(
  parameter int unsigned INITIAL_CREDIT   = 4090,
  parameter int unsigned CREDIT_THRESHOLD = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  glip_uart_egress_scheduler_if.master         sched_bus,
  input  logic                                 transfer_in,
  input  logic                                 uart_cts_n,
  output logic [11:0]                          credit_pending,
  output logic                                 busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_ESC2,
    ST_MSG0,
    ST_MSG1,
    ST_MSG2
  } state_t;

  localparam logic [7:0]  ESC_BYTE = 8'hFE;
  localparam logic [11:0] INIT_CRD = 12'(INITIAL_CREDIT);
  localparam logic [11:0] THRESH   = 12'(CREDIT_THRESHOLD);

  state_t      state_q, state_d;
  logic        tx_en_q, tx_en_d;
  logic        ready_q, ready_d;
  logic        grant_q, grant_d;
  logic        kind_ack_q, kind_ack_d;
  logic [5:0]  code_q, code_d;
  logic [11:0] snap_q, snap_d;
  logic [7:0]  data_q, data_d;
  logic [11:0] pending_q, pending_d;

  logic        byte_done;
  logic        cred_go;
  logic        take_snap;
  logic [11:0] pending_base;
  logic [12:0] pending_sum;

  assign byte_done = tx_en_q & sched_bus.tx_done;
  // Small credit goes out only when no data is waiting behind it.
  assign cred_go   = (pending_q != 12'd0) &&
                     ((pending_q >= THRESH) || !sched_bus.egress_in_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_en_q    <= 1'b0;
      ready_q    <= 1'b0;
      grant_q    <= 1'b0;
      kind_ack_q <= 1'b0;
      code_q     <= 6'd0;
      snap_q     <= 12'd0;
      data_q     <= 8'd0;
      pending_q  <= INIT_CRD;
    end else begin
      state_q    <= state_d;
      tx_en_q    <= tx_en_d;
      ready_q    <= ready_d;
      grant_q    <= grant_d;
      kind_ack_q <= kind_ack_d;
      code_q     <= code_d;
      snap_q     <= snap_d;
      data_q     <= data_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_en_d    = tx_en_q;
    ready_d    = 1'b0;
    grant_d    = 1'b0;
    kind_ack_d = kind_ack_q;
    code_d     = code_q;
    snap_d     = snap_q;
    data_d     = data_q;
    take_snap  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The grant/ready pulse cycle still shows the old request, so it is masked.
        if (!uart_cts_n) begin
          if (sched_bus.ctrl_ack_req && !grant_q) begin
            state_d    = ST_MSG0;
            tx_en_d    = 1'b1;
            kind_ack_d = 1'b1;
            code_d     = sched_bus.ctrl_ack_code;
          end else if (cred_go) begin
            state_d    = ST_MSG0;
            tx_en_d    = 1'b1;
            kind_ack_d = 1'b0;
            snap_d     = pending_q;
            take_snap  = 1'b1;
          end else if (sched_bus.egress_in_valid && !ready_q) begin
            state_d = ST_DATA;
            tx_en_d = 1'b1;
            data_d  = sched_bus.egress_in_data;
          end
        end
      end
      default: begin
        if (byte_done) begin
          tx_en_d = 1'b0;
          unique case (state_q)
            ST_DATA: begin
              if (data_q == ESC_BYTE) begin
                state_d = ST_ESC2;
              end else begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
              end
            end
            ST_ESC2: begin
              state_d = ST_IDLE;
              ready_d = 1'b1;
            end
            ST_MSG0: state_d = ST_MSG1;
            ST_MSG1: begin
              if (kind_ack_q) begin
                state_d = ST_IDLE;
                grant_d = 1'b1;
              end else begin
                state_d = ST_MSG2;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end else if (!tx_en_q && !uart_cts_n) begin
          tx_en_d = 1'b1;
        end
      end
    endcase

    // A transfer coinciding with a snapshot lands after the subtraction.
    pending_base = take_snap ? 12'd0 : pending_q;
    pending_sum  = {1'b0, pending_base} + {12'd0, transfer_in};
    pending_d    = pending_sum[12] ? 12'hFFF : pending_sum[11:0];
  end

  always_comb begin
    sched_bus.tx_data         = 8'h00;
    sched_bus.tx_enable       = tx_en_q;
    sched_bus.egress_in_ready = ready_q;
    sched_bus.ctrl_ack_grant  = grant_q;
    credit_pending            = pending_q;
    busy                      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_DATA: sched_bus.tx_data = data_q;
      ST_ESC2: sched_bus.tx_data = ESC_BYTE;
      ST_MSG0: sched_bus.tx_data = ESC_BYTE;
      ST_MSG1: sched_bus.tx_data = kind_ack_q ? {2'b11, code_q} : {2'b10, snap_q[11:6]};
      ST_MSG2: sched_bus.tx_data = {2'b10, snap_q[5:0]};
      default: sched_bus.tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_glip_uart_egress_scheduler.sv
// Directed bench: a table of arbitration/escape vectors plus hand-written sequences
// for credit snapshot, flow control, and reset mid-message.
module tb_glip_uart_egress_scheduler;

  localparam int TX_LEN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        transfer_in = 1'b0;
  logic        uart_cts_n = 1'b1;
  logic [11:0] credit_pending;
  logic        busy;

  logic        tx_done_r = 1'b0;
  logic        fifo_valid = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        ack_req = 1'b0;
  logic [5:0]  ack_code = 6'h00;

  glip_uart_egress_scheduler_if bus ();

  assign bus.tx_done         = tx_done_r;
  assign bus.egress_in_valid = fifo_valid;
  assign bus.egress_in_data  = fifo_data;
  assign bus.ctrl_ack_req    = ack_req;
  assign bus.ctrl_ack_code   = ack_code;

  glip_uart_egress_scheduler #(
    .INITIAL_CREDIT   (4090),
    .CREDIT_THRESHOLD (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sched_bus      (bus),
    .transfer_in    (transfer_in),
    .uart_cts_n     (uart_cts_n),
    .credit_pending (credit_pending),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         ready_cnt = 0;
  int         grant_cnt = 0;
  int         hold_errs = 0;
  int         tx_cnt = 0;
  logic [7:0] hold_byte = 8'h00;
  logic [7:0] fifo_q[$];
  logic [7:0] wire_q[$];

  typedef struct {
    logic            is_ack;
    logic [5:0]      code;
    int              nd;
    logic [0:2][7:0] d;
    int              ne;
    logic [0:5][7:0] e;
    int              rdy;
    int              gnt;
  } vec_t;

  vec_t vecs[6];

  // UART engine model: holds each byte TX_LEN cycles, then one-cycle tx_done.
  always @(negedge clk) begin
    if (tx_done_r) begin
      tx_done_r = 1'b0;
    end else if (bus.tx_enable) begin
      if (tx_cnt == 0) begin
        hold_byte = bus.tx_data;
        wire_q.push_back(bus.tx_data);
      end else if (bus.tx_data !== hold_byte) begin
        hold_errs++;
      end
      tx_cnt++;
      if (tx_cnt == TX_LEN) begin
        tx_done_r = 1'b1;
        tx_cnt    = 0;
      end
    end else begin
      tx_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle step; also plays the FWFT FIFO and the ack requester.
  task automatic tick();
    @(negedge clk);
    #1;
    if (bus.egress_in_ready) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      ready_cnt++;
    end
    if (bus.ctrl_ack_grant) begin
      grant_cnt++;
      ack_req = 1'b0;
    end
    fifo_valid = (fifo_q.size() != 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int  n;
    logic idle;
    n    = 0;
    idle = 1'b0;
    while (!idle && n < 3000) begin
      tick();
      n++;
      idle = !busy && !bus.tx_enable && fifo_q.size() == 0 && !ack_req &&
             credit_pending == 12'd0;
    end
    check({tag, "_settle"}, 32'(idle), 32'd1);
    repeat (3) tick();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!tx_done_r && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_tx_done_seen"}, 32'(tx_done_r), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input int base, input int n,
                             input logic [0:5][7:0] e);
    check({tag, "_count"}, 32'(wire_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < wire_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(wire_q[base + i]), 32'(e[i]));
    end
  endtask

  initial begin
    int base;
    int r0;
    int g0;
    int n;

    vecs[0] = '{is_ack:1'b0, code:6'h00, nd:3, d:{8'h41, 8'hFE, 8'h42},
                ne:4, e:{8'h41, 8'hFE, 8'hFE, 8'h42, 8'h00, 8'h00}, rdy:3, gnt:0};
    vecs[1] = '{is_ack:1'b1, code:6'h05, nd:1, d:{8'h33, 8'h00, 8'h00},
                ne:3, e:{8'hFE, 8'hC5, 8'h33, 8'h00, 8'h00, 8'h00}, rdy:1, gnt:1};
    vecs[2] = '{is_ack:1'b0, code:6'h00, nd:1, d:{8'h7F, 8'h00, 8'h00},
                ne:1, e:{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, rdy:1, gnt:0};
    vecs[3] = '{is_ack:1'b0, code:6'h00, nd:2, d:{8'hFE, 8'hFE, 8'h00},
                ne:4, e:{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'h00, 8'h00}, rdy:2, gnt:0};
    vecs[4] = '{is_ack:1'b1, code:6'h3F, nd:0, d:{8'h00, 8'h00, 8'h00},
                ne:2, e:{8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, rdy:0, gnt:1};
    vecs[5] = '{is_ack:1'b1, code:6'h00, nd:1, d:{8'h00, 8'h00, 8'h00},
                ne:3, e:{8'hFE, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00}, rdy:1, gnt:1};

    // Reset values
    repeat (2) tick();
    check("rst_tx_enable", 32'(bus.tx_enable), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_ready", 32'(bus.egress_in_ready), 32'd0);
    check("rst_grant", 32'(bus.ctrl_ack_grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(credit_pending), 32'd4090);
    rst_n = 1'b1;
    repeat (3) tick();
    check("cts_blocks_start", 32'(busy), 32'd0);

    // Initial credit announcement, request latency and inter-byte gap
    base = wire_q.size();
    uart_cts_n = 1'b0;
    tick();
    check("lat_tx_enable", 32'(bus.tx_enable), 32'd1);
    check("lat_tx_data", 32'(bus.tx_data), 32'hFE);
    check("snap_pending", 32'(credit_pending), 32'd0);
    wait_done("init0");
    tick();
    check("gap_tx_enable_low", 32'(bus.tx_enable), 32'd0);
    tick();
    check("gap_tx_enable_high", 32'(bus.tx_enable), 32'd1);
    check("gap_tx_data", 32'(bus.tx_data), 32'hBF);
    wait_idle("init");
    check_bytes("init_credit", base, 3, {8'hFE, 8'hBF, 8'hBA, 8'h00, 8'h00, 8'h00});
    check("init_pending_after", 32'(credit_pending), 32'd0);

    // 70 transfers, the last one coinciding with the snapshot
    uart_cts_n  = 1'b1;
    transfer_in = 1'b1;
    repeat (69) tick();
    check("cred_accum", 32'(credit_pending), 32'd69);
    base = wire_q.size();
    uart_cts_n = 1'b0;
    tick();
    transfer_in = 1'b0;
    check("cred_coincide_pending", 32'(credit_pending), 32'd1);
    check("cred_start", 32'(bus.tx_enable), 32'd1);
    wait_idle("cred");
    check_bytes("cred_msgs", base, 6, {8'hFE, 8'h81, 8'h85, 8'hFE, 8'h80, 8'h81});

    // Table-driven arbitration and escape vectors
    for (int k = 0; k < 6; k++) begin
      uart_cts_n = 1'b1;
      base = wire_q.size();
      r0   = ready_cnt;
      g0   = grant_cnt;
      for (int i = 0; i < vecs[k].nd; i++) fifo_q.push_back(vecs[k].d[i]);
      if (vecs[k].is_ack) begin
        ack_code = vecs[k].code;
        ack_req  = 1'b1;
      end
      tick();
      uart_cts_n = 1'b0;
      wait_idle($sformatf("v%0d", k));
      check_bytes($sformatf("v%0d", k), base, vecs[k].ne, vecs[k].e);
      check($sformatf("v%0d_ready", k), 32'(ready_cnt - r0), 32'(vecs[k].rdy));
      check($sformatf("v%0d_grant", k), 32'(grant_cnt - g0), 32'(vecs[k].gnt));
    end

    // cts_n raised during the second byte of an escape pair
    uart_cts_n = 1'b0;
    base = wire_q.size();
    r0   = ready_cnt;
    fifo_q.push_back(8'hFE);
    tick();
    wait_done("esc_first");
    n = 0;
    tick();
    while (!bus.tx_enable && n < 50) begin
      tick();
      n++;
    end
    check("esc_second_started", 32'(bus.tx_enable), 32'd1);
    uart_cts_n = 1'b1;
    fifo_q.push_back(8'h55);
    repeat (20) tick();
    check_bytes("esc_pair_held", base, 2, {8'hFE, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00});
    check("esc_held_tx_enable", 32'(bus.tx_enable), 32'd0);
    check("esc_held_busy", 32'(busy), 32'd0);
    check("esc_held_ready", 32'(ready_cnt - r0), 32'd1);
    uart_cts_n = 1'b0;
    wait_idle("esc");
    check_bytes("esc_resume", base, 3, {8'hFE, 8'hFE, 8'h55, 8'h00, 8'h00, 8'h00});
    check("esc_ready_total", 32'(ready_cnt - r0), 32'd2);

    // Reset in the middle of an ack MSG1 byte, then credit saturation
    g0 = grant_cnt;
    ack_code = 6'h12;
    ack_req  = 1'b1;
    n = 0;
    while (!(bus.tx_enable && bus.tx_data == 8'hD2) && n < 100) begin
      tick();
      n++;
    end
    check("ack_msg1_reached", 32'(bus.tx_data), 32'hD2);
    rst_n      = 1'b0;
    ack_req    = 1'b0;
    uart_cts_n = 1'b1;
    tick();
    check("midrst_tx_enable", 32'(bus.tx_enable), 32'd0);
    check("midrst_tx_data", 32'(bus.tx_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant", 32'(bus.ctrl_ack_grant), 32'd0);
    check("midrst_pending", 32'(credit_pending), 32'd4090);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("midrst_no_grant", 32'(grant_cnt - g0), 32'd0);
    transfer_in = 1'b1;
    repeat (10) tick();
    transfer_in = 1'b0;
    check("sat_pending", 32'(credit_pending), 32'd4095);
    base = wire_q.size();
    uart_cts_n = 1'b0;
    wait_idle("sat");
    check_bytes("sat_msg", base, 3, {8'hFE, 8'hBF, 8'hBF, 8'h00, 8'h00, 8'h00});

    check("tx_hold_stable", 32'(hold_errs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
